// File: rtl/tt_um_matmul_free.sv
// Multiplier-free ternary-weight neuron: streams signed activations, accumulates +/-x,
// and on the last beat emits a shifted, optionally ReLU'd, clipped 8-bit result.
module tt_um_matmul_free (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [1:0] wcode;
  logic       valid, last, cfg;
  logic       unused_uio;

  assign wcode      = uio_in[1:0];
  assign valid      = uio_in[2];
  assign last       = uio_in[3];
  assign cfg        = uio_in[4];
  assign unused_uio = &{1'b0, uio_in[7:5]};

  logic signed [15:0] acc;
  logic               vovf;
  logic [2:0]         shift;
  logic               relu_en;
  logic               out_valid, sat_q, ovf_q;

  logic signed [16:0] x_ext, sum;
  logic signed [15:0] acc_nxt, shifted, relu_v;
  logic signed [7:0]  clip_v;
  logic               clamp, clip_hit;

  assign x_ext = {{9{ui_in[7]}}, ui_in};

  // 17-bit add/sub cannot wrap, so the clamp test below is exact.
  always_comb begin
    sum = {acc[15], acc};
    if (wcode == 2'b01)      sum = sum + x_ext;
    else if (wcode == 2'b11) sum = sum - x_ext;
  end

  always_comb begin
    clamp   = 1'b0;
    acc_nxt = sum[15:0];
    if (sum > 17'sd32767) begin
      acc_nxt = 16'sh7fff;
      clamp   = 1'b1;
    end else if (sum < -17'sd32768) begin
      acc_nxt = 16'sh8000;
      clamp   = 1'b1;
    end
  end

  always_comb begin
    shifted  = acc_nxt >>> shift;
    relu_v   = (relu_en && shifted[15]) ? 16'sd0 : shifted;
    clip_hit = 1'b1;
    if (relu_v > 16'sd127)       clip_v = 8'sd127;
    else if (relu_v < -16'sd128) clip_v = -8'sd128;
    else begin
      clip_v   = relu_v[7:0];
      clip_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      vovf      <= 1'b0;
      shift     <= '0;
      relu_en   <= 1'b0;
      uo_out    <= '0;
      out_valid <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (ena) begin
      out_valid <= 1'b0;
      if (valid) begin
        if (last) begin
          acc       <= '0;
          vovf      <= 1'b0;
          uo_out    <= clip_v;
          sat_q     <= clip_hit;
          ovf_q     <= vovf | clamp;
          out_valid <= 1'b1;
        end else begin
          acc  <= acc_nxt;
          vovf <= vovf | clamp;
        end
      end else if (cfg) begin
        shift   <= ui_in[2:0];
        relu_en <= ui_in[3];
      end
    end
  end

  assign uio_out = {ovf_q, sat_q, out_valid, 5'b0};
  assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_matmul_free.sv
// Directed + randomized bench for tt_um_matmul_free against an integer reference model.
module tb_tt_um_matmul_free;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic ena, clk, rst_n;

  int checks = 0;
  int failures = 0;

  // reference model state (plain integers)
  int m_acc, m_shift, m_uo;
  bit m_vovf, m_relu, m_sat, m_ovf, m_ov;

  tt_um_matmul_free dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div_pow2(input int a, input int s);
    int d, r;
    d = 1 << s;
    r = ((a % d) + d) % d;
    return (a - r) / d;
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] e_uo;
    e_uo = m_uo[7:0];
    chk({tag, ".uo_out"}, uo_out, e_uo);
    chk({tag, ".uio_out"}, uio_out, {m_ovf, m_sat, m_ov, 5'b0});
    chk({tag, ".uio_oe"}, uio_oe, 8'hE0);
  endtask

  task automatic model_reset();
    m_acc = 0; m_vovf = 0; m_shift = 0; m_relu = 0;
    m_uo = 0; m_sat = 0; m_ovf = 0; m_ov = 0;
  endtask

  // one clock of stimulus; model updated at the edge, outputs checked on the falling edge
  task automatic beat(input bit en, input bit valid, input bit last, input bit cfg,
                      input int x, input logic [1:0] wc, input string tag);
    int w, s, v;
    bit clamp;
    ena    = en;
    ui_in  = x[7:0];
    uio_in = {3'b0, cfg, last, valid, wc};
    @(posedge clk);
    if (en) begin
      m_ov = 0;
      if (valid) begin
        w = (wc == 2'b01) ? 1 : (wc == 2'b11) ? -1 : 0;
        s = m_acc + w * x;
        clamp = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (last) begin
          v = floor_div_pow2(s, m_shift);
          if (m_relu && v < 0) v = 0;
          m_sat = (v > 127) || (v < -128);
          if (v > 127) v = 127;
          if (v < -128) v = -128;
          m_uo = v;
          m_ovf = m_vovf | clamp;
          m_ov = 1;
          m_acc = 0; m_vovf = 0;
        end else begin
          m_acc = s;
          m_vovf = m_vovf | clamp;
        end
      end else if (cfg) begin
        m_shift = x & 7;
        m_relu  = (x >> 3) & 1;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic data(input int x, input logic [1:0] wc, input bit last, input string tag);
    beat(1, 1, last, 0, x, wc, tag);
  endtask

  task automatic config_word(input int word);
    beat(1, 0, 0, 1, word, 2'b00, "cfg");
  endtask

  task automatic idle(input string tag);
    beat(1, 0, 0, 0, 0, 2'b00, tag);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n, x;
    logic [1:0] wc;
    ena = 0; ui_in = 0; uio_in = 0; rst_n = 1;
    model_reset();
    @(negedge clk);
    reset_pulse("reset");
    chk("reset.uo_abs", uo_out, 8'h00);
    chk("reset.uio_abs", uio_out, 8'h00);

    // basic vector: 10 - 20 + 30 = 20
    data(10, 2'b01, 0, "basic1");
    data(20, 2'b11, 0, "basic2");
    data(30, 2'b01, 1, "basic3");
    chk("basic.uo_abs", uo_out, 8'd20);
    chk("basic.ov_abs", uio_out[5], 1'b1);
    idle("basic.after");
    chk("basic.ov_low", uio_out[5], 1'b0);
    chk("basic.hold", uo_out, 8'd20);

    // ReLU on, then off
    config_word(8'h08);
    data(-5, 2'b01, 1, "relu_on");
    chk("relu_on.abs", uo_out, 8'h00);
    config_word(8'h00);
    data(-5, 2'b01, 1, "relu_off");
    chk("relu_off.abs", uo_out, 8'hFB);

    // shift by 3 with floor semantics
    config_word(3);
    data(100, 2'b01, 1, "shift_pos");
    chk("shift_pos.abs", uo_out, 8'd12);
    data(100, 2'b11, 1, "shift_neg");
    chk("shift_neg.abs", uo_out, 8'hF3);

    // clip and accumulator overflow
    config_word(0);
    data(100, 2'b01, 0, "clip1");
    data(100, 2'b01, 0, "clip2");
    data(100, 2'b01, 1, "clip3");
    chk("clip.abs", uio_out[7:5], 3'b011);
    for (int i = 0; i < 300; i++) data(127, 2'b01, i == 299, "ovf");
    chk("ovf.uo_abs", uo_out, 8'd127);
    chk("ovf.flags_abs", uio_out[7:5], 3'b111);
    data(1, 2'b01, 1, "after_ovf");
    chk("after_ovf.abs", uo_out, 8'd1);
    chk("after_ovf.flags_abs", uio_out[7:5], 3'b001);

    // enable gating on beat 2, and cfg ignored when valid
    data(10, 2'b01, 0, "ena1");
    beat(0, 1, 0, 0, 20, 2'b11, "ena2_off");
    beat(1, 1, 0, 1, 30, 2'b01, "ena3_cfgvalid");
    data(0, 2'b10, 1, "ena4");
    chk("ena.abs", uo_out, 8'd40);

    // reset mid-vector: partial sum discarded, no out_valid
    data(50, 2'b01, 0, "rst_mid1");
    @(negedge clk);
    reset_pulse("rst_mid");
    idle("rst_mid.idle");
    chk("rst_mid.no_ov", uio_out[5], 1'b0);
    data(7, 2'b01, 1, "rst_mid.new");
    chk("rst_mid.new_abs", uo_out, 8'd7);

    // back-to-back single-beat vectors
    data(3, 2'b01, 1, "b2b1");
    data(4, 2'b11, 1, "b2b2");
    chk("b2b.abs", uo_out, 8'hFC);

    // randomized vectors with config, idle, disabled and last-without-valid beats
    for (int v = 0; v < 60; v++) begin
      if ($urandom_range(0, 3) == 0) config_word($urandom_range(0, 255));
      n = $urandom_range(1, 12);
      for (int b = 0; b < n; b++) begin
        case ($urandom_range(0, 7))
          0: beat(0, $urandom_range(0, 1), 0, 0, $urandom_range(0, 255), 2'b01, "rnd_off");
          1: beat(1, 0, 1, 0, $urandom_range(0, 255), 2'b01, "rnd_lastnv");
          default: ;
        endcase
        x  = int'($signed(8'($urandom_range(0, 255))));
        wc = 2'($urandom_range(0, 3));
        beat(1, 1, b == n - 1, $urandom_range(0, 1), x, wc, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_matmul_free.md
TT_UM_MATMUL_FREE -- requirements
Module: tt_um_matmul_free

Interface
REQ-001 Parameters: none; accumulator width is fixed at 16 bits (signed); shift reset value 0; ReLU reset value off.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous, active-low.
REQ-004 ena  input  1  Design enable; when 0, all registers hold and inputs are ignored.
REQ-005 ui_in  input  8  Signed activation x in a data beat; config word in a config beat.
REQ-006 uio_in  input  8  [1:0] ternary weight code, [2] valid, [3] last, [4] cfg, [7:5] unused.
REQ-007 uo_out  output  8  Registered signed 8-bit neuron result.
REQ-008 uio_out  output  8  [4:0]=0, [5] out_valid, [6] sat, [7] ovf.
REQ-009 uio_oe  output  8  Constant 8'hE0; bits [7:5] drive, bits [4:0] are inputs.

Function
REQ-010 Weight code decode: 2'b01 = +1, 2'b11 = -1, 2'b00 and 2'b10 = 0.
REQ-011 Data beat (ena=1, valid=1): acc <= sat16(acc + w*x) with x sign-extended; w=0 leaves acc unchanged; add/subtract only, no multiplier.
REQ-012 Accumulator saturation: acc clamps to [-32768, 32767]; any clamp sets sticky vector overflow flag vovf.
REQ-013 Last beat (valid=1, last=1) computes final = sat16(acc + w*x) in the same cycle.
REQ-014 On a last beat, acc and vovf clear to 0 on that edge, so the next beat starts a new vector.
REQ-015 Post-processing of final, in order: arithmetic right shift by shift[2:0] (floor); ReLU (negative -> 0) if relu_en; clip to [-128, 127].
REQ-016 On the edge of a last beat: uo_out <= the post-processed value.
REQ-017 On the same edge: sat <= 1 iff the clip in REQ-015 changed the value, and ovf <= vovf OR a clamp on that beat.
REQ-018 uo_out, sat and ovf hold until the next last beat.
REQ-019 out_valid is high for exactly one cycle, the cycle after the last beat edge (latency 1); back-to-back single-beat vectors give out_valid high on consecutive cycles.
REQ-020 Config beat (ena=1, cfg=1, valid=0): shift <= ui_in[2:0], relu_en <= ui_in[3]; acc is unaffected.
REQ-021 When cfg=1 and valid=1 together, the data beat is processed and cfg is ignored.
REQ-022 Beats with valid=0 and cfg=0 leave all state unchanged.
REQ-023 last is ignored when valid=0.

Reset
REQ-024 rst_n=0 immediately clears acc, vovf, shift, relu_en, uo_out, out_valid, sat and ovf to 0, independent of clk.
REQ-025 uio_oe=8'hE0 and uio_out[4:0]=0 at all times, including during reset.
REQ-026 Reset mid-vector discards the partial sum; no out_valid is produced for that vector.

Verification
REQ-027 Reset: assert rst_n=0 -> uo_out=0, uio_out=0, uio_oe=8'hE0.
REQ-028 Basic vector: shift=0, ReLU off, x=[10,20,30], w=[+1,-1,+1] with last on beat 3 -> next cycle out_valid=1 and uo_out=20, then out_valid=0 with uo_out still 20.
REQ-029 ReLU: config with ui_in=8'h08, then x=-5, w=+1, last -> uo_out=0 and sat=0; same vector with ReLU off -> uo_out=8'hFB (-5).
REQ-030 Shift: config shift=3; sum 100 -> uo_out=12; sum -100 -> uo_out=-13 (8'hF3).
REQ-031 Output clipping and accumulator overflow: shift=0, x=[100,100,100], all +1 -> uo_out=127, sat=1, ovf=0; 300 beats of x=127, w=+1 -> uo_out=127, sat=1, ovf=1; a following vector of x=[1], w=+1 -> uo_out=1, sat=0, ovf=0.
REQ-032 Enable gating: ena=0 during beat 2 of REQ-028's vector -> that beat is ignored, and the result is 40; a rst_n pulse mid-vector -> no out_valid for that vector.
